// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO plus launch sequencer feeding a UART transmitter through its
//   begin/busy/done handshake. Producers may write up to one byte per clock
//   without knowing anything about the transmitter state.
//
// Parameters
//   DEPTH       FIFO entries (power of two, >= 2)
//   ADDR_WIDTH  log2(DEPTH)
//
// Ports
//   i_clock              system clock, posedge
//   i_reset              synchronous active-high reset
//   i_wrEn / i_wrData    enqueue strobe and byte (ignored while o_full)
//   o_full / o_empty     occupancy flags, derived from the registered count
//   o_idle               nothing buffered, sequencer IDLE, transmitter not busy
//   o_txBegin/o_txData   one-cycle launch strobe and the launched byte
//   i_txBusy / i_txDone  transmitter busy level and completion pulse
//
// Optional build macro UART_TX_FIFO_STATUS_EN adds:
//   o_count     current occupancy (ADDR_WIDTH+1 bits)
//   o_overflow  sticky: a write was attempted while full; cleared by reset
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_wrEn,
  input  logic [7:0]            i_wrData,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_idle,
  output logic                  o_txBegin,
  output logic [7:0]            o_txData,
  input  logic                  i_txBusy,
  input  logic                  i_txDone
`ifdef UART_TX_FIFO_STATUS_EN
  ,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow
`endif
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr, rdPtr;
  logic [ADDR_WIDTH:0]   count;
  state_t                state, stateNext;
  logic                  wrFire, popFire;

  assign o_full  = (count == FULL_CNT);
  assign o_empty = (count == '0);

  // Pop only from IDLE on the cycle that moves to LAUNCH; the registered
  // count gives the one-cycle write-to-read latency for free.
  assign wrFire  = i_wrEn && !o_full;
  assign popFire = (state == IDLE) && !o_empty && !i_txBusy;

  // Storage has no reset: stale contents are unreachable once pointers clear.
  always_ff @(posedge i_clock) begin
    if (wrFire) mem[wrPtr] <= i_wrData;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      o_txData <= 8'h00;
    end else begin
      if (wrFire) wrPtr <= wrPtr + 1'b1;
      if (popFire) begin
        rdPtr    <= rdPtr + 1'b1;
        o_txData <= mem[rdPtr];
      end
      case ({wrFire, popFire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Sequencer: state register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= IDLE;
    else         state <= stateNext;
  end

  // Sequencer: next state. i_txDone outside WAIT_DONE is deliberately ignored.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (popFire)  stateNext = LAUNCH;
      LAUNCH:                  stateNext = WAIT_BUSY;
      WAIT_BUSY: if (i_txBusy) stateNext = WAIT_DONE;
      WAIT_DONE: if (i_txDone) stateNext = IDLE;
      default:                 stateNext = IDLE;
    endcase
  end

  // Sequencer: outputs. The busy term in o_idle also covers a frame still
  // in flight across a reset, since the transmitter itself is not reset.
  always_comb begin
    o_txBegin = (state == LAUNCH);
    o_idle    = o_empty && (state == IDLE) && !i_txBusy;
  end

`ifdef UART_TX_FIFO_STATUS_EN
  assign o_count = count;

  always_ff @(posedge i_clock) begin
    if (i_reset)                o_overflow <= 1'b0;
    else if (i_wrEn && o_full)  o_overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic       clk = 1'b0;
  logic       rst, wrEn, full, empty, idle, txBegin, txBusy, txDone;
  logic [7:0] wrData, txData;
`ifdef UART_TX_FIFO_STATUS_EN
  logic [AW:0] cnt;
  logic        ovf;
`endif

  // transmitter: behavioural model or manual drive
  logic autoTx, manBusy, manDone, mdlBusy = 1'b0, mdlDone = 1'b0;
  int   frameLen, txTimer = 0;
  assign txBusy = autoTx ? mdlBusy : manBusy;
  assign txDone = autoTx ? mdlDone : manDone;

  int total = 0, bad = 0, launchCnt = 0;
  logic launchOk = 1'b1, prevBegin = 1'b0;
  logic [7:0] sbq[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .i_clock(clk), .i_reset(rst), .i_wrEn(wrEn), .i_wrData(wrData),
    .o_full(full), .o_empty(empty), .o_idle(idle),
    .o_txBegin(txBegin), .o_txData(txData),
    .i_txBusy(txBusy), .i_txDone(txDone)
`ifdef UART_TX_FIFO_STATUS_EN
    , .o_count(cnt), .o_overflow(ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // transmitter model: busy from the negedge after a launch, done after frameLen
  always @(negedge clk) begin
    if (autoTx) begin
      if (mdlDone) begin
        mdlDone = 1'b0;
        mdlBusy = 1'b0;
      end else if (txTimer > 0) begin
        txTimer--;
        if (txTimer == 0) mdlDone = 1'b1;
      end
      if (txBegin) begin
        mdlBusy = 1'b1;
        txTimer = frameLen;
      end
    end
  end

  // launch monitor / scoreboard consumer
  always begin
    logic [8:0] expD;
    @(posedge clk); #1;
    if (rst || txDone) launchOk = 1'b1;
    if (txBegin) begin
      launchCnt++;
      chk("beginWidth", {31'd0, prevBegin}, 0);
      chk("launchGate", {31'd0, launchOk}, 1);
      launchOk = 1'b0;
      expD = (sbq.size() != 0) ? {1'b0, sbq.pop_front()} : 9'h100;
      chk("txData", {24'd0, txData}, {23'd0, expD});
    end
    prevBegin = txBegin;
  end

  task automatic wr(input logic [7:0] d, input bit accept);
    @(negedge clk);
    wrEn = 1'b1; wrData = d;
    if (accept) sbq.push_back(d);
    @(posedge clk); #1;
    wrEn = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!(sbq.size() == 0 && idle) && n < 3000);
    chk("drained", {31'd0, (sbq.size() == 0 && idle)}, 1);
  endtask

  task automatic doReset();
    @(negedge clk); rst = 1'b1; sbq.delete();
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int lc, n;
    rst = 1'b1; wrEn = 1'b0; wrData = 8'h00;
    autoTx = 1'b1; manBusy = 1'b0; manDone = 1'b0; frameLen = 4;
    @(posedge clk); #1;
    chk("rstFull", full, 0);
    chk("rstEmpty", empty, 1);
    chk("rstIdle", idle, 1);
    chk("rstBegin", txBegin, 0);
    chk("rstData", txData, 8'h00);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // single byte: begin exactly two edges after the write
    wr(8'hA5, 1);
    chk("t1Empty", empty, 0);
    chk("t1BeginK", txBegin, 0);
    @(posedge clk); #1;
    chk("t1BeginK1", txBegin, 1);
    chk("t1Data", txData, 8'hA5);
    @(posedge clk); #1;
    chk("t1BeginK2", txBegin, 0);
    waitDrain();
    chk("t1EmptyAfter", empty, 1);

    // burst to full while transmitter busy, then overflow write
    autoTx = 1'b0; manBusy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr(8'(i), 1);
      if (i == 14) chk("notFull15", full, 0);
    end
    chk("full16", full, 1);
    wr(8'hFF, 0);
    chk("fullAfterDrop", full, 1);
`ifdef UART_TX_FIFO_STATUS_EN
    chk("ovf", ovf, 1);
    chk("cnt16", cnt, 16);
`endif
    chk("noLaunchBusy", launchCnt, 1);
    @(negedge clk); manBusy = 1'b0; autoTx = 1'b1;
    waitDrain();
    chk("burstLaunches", launchCnt, 17);
`ifdef UART_TX_FIFO_STATUS_EN
    chk("ovfSticky", ovf, 1);
`endif

    // simultaneous write and pop at count=3
    autoTx = 1'b0; manBusy = 1'b1;
    wr(8'h10, 1); wr(8'h11, 1); wr(8'h12, 1);
    @(negedge clk);
    manBusy = 1'b0; autoTx = 1'b1;
    wrEn = 1'b1; wrData = 8'h13; sbq.push_back(8'h13);
    @(posedge clk); #1;
    wrEn = 1'b0;
    chk("simBegin", txBegin, 1);
    chk("simData", txData, 8'h10);
    chk("simEmpty", empty, 0);
`ifdef UART_TX_FIFO_STATUS_EN
    chk("simCnt", cnt, 3);
`endif
    waitDrain();

    // pointer wrap: 40 single write/drain rounds
    for (int i = 0; i < 40; i++) begin
      wr(8'(i * 7 + 3), 1);
      waitDrain();
    end
    chk("wrapLaunches", launchCnt, 61);

    // reset while in WAIT_DONE with 5 bytes queued
    frameLen = 30;
    for (int i = 0; i < 6; i++) wr(8'h20 + 8'(i), 1);
    repeat (4) @(posedge clk); #1;
`ifdef UART_TX_FIFO_STATUS_EN
    chk("queued5", cnt, 5);
`endif
    chk("preRstBusy", txBusy, 1);
    lc = launchCnt;
    doReset();
    @(posedge clk); #1;
    chk("rstMidEmpty", empty, 1);
    chk("rstMidBegin", txBegin, 0);
    chk("rstMidIdle", idle, 0);
    n = 0;
    while (mdlBusy && n < 200) begin @(posedge clk); #1; n++; end
    chk("busyFell", mdlBusy, 0);
    repeat (10) @(posedge clk); #1;
    chk("rstNoLaunch", launchCnt, lc);
    chk("rstIdleEnd", idle, 1);
    frameLen = 4;

    // busy never rises after launch: sequencer must park in WAIT_BUSY
    autoTx = 1'b0; manBusy = 1'b0; manDone = 1'b0;
    lc = launchCnt;
    wr(8'h5A, 1);
    repeat (50) @(posedge clk); #1;
    chk("wbOneLaunch", launchCnt, lc + 1);
    chk("wbNotIdle", idle, 0);
    @(negedge clk); manDone = 1'b1;
    @(negedge clk); manDone = 1'b0;
    @(posedge clk); #1;
    chk("wbDoneIgnored", idle, 0);
    @(negedge clk); manBusy = 1'b1;
    @(negedge clk);
    @(negedge clk); manDone = 1'b1;
    @(negedge clk); manDone = 1'b0; manBusy = 1'b0;
    @(posedge clk); #1;
    chk("wbBackIdle", idle, 1);
    chk("wbNoExtra", launchCnt, lc + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
